uart_tx_fifo: RTL

- Parametrised successor to the single-byte UART transmitter.
- Buffers words in an internal FIFO with a valid/ready write port.
- Serialises each word LSB-first with runtime-selectable data length and 1 or 2 stop bits; parity is an optional build feature.
- Sits between the bus register interface and the tx pin of the UART peripheral.

---
 rtl/uart_tx_fifo.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO and runtime frame format.
// Build with UART_TX_PARITY_EN defined to add the parity bit state.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            tx_en_i,
  input  logic [CNT_W-1:0]                clks_per_bit_i,
  input  logic [3:0]                      data_len_i,
  input  logic                            stop2_i,
  input  logic                            parity_en_i,
  input  logic                            parity_odd_i,
  input  logic [DATA_W-1:0]               wdata_i,
  input  logic                            wvalid_i,
  output logic                            wready_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic                            tx_o,
  output logic                            busy_o,
  output logic                            tx_done_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [LW-1:0]     level_q;
  logic              full, empty, push, pop;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cpb_q, cpb_d, cpb_eff;
  logic [3:0]        idx_q, idx_d, len_q, len_d, len_eff;
  logic [DATA_W-1:0] word_q, word_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d, done_q, done_d;
  logic              bit_end;

`ifdef UART_TX_PARITY_EN
  logic              par_en_q, par_en_d, par_q, par_d;
  logic [DATA_W-1:0] mask;
  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_W; i++)
      mask[i] = (i < int'(len_eff));
  end
`else
  logic unused_par;
  assign unused_par = parity_en_i ^ parity_odd_i;
`endif

  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign push     = wvalid_i && !full;
  assign cpb_eff  = (clks_per_bit_i == '0) ? CNT_W'(1) : clks_per_bit_i;
  assign len_eff  = (data_len_i == 4'd0 || data_len_i > 4'(DATA_W))
                  ? 4'(DATA_W) : data_len_i;
  assign bit_end  = (cnt_q == cpb_q - CNT_W'(1));

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cpb_d   = cpb_q;
    idx_d   = idx_q;
    len_d   = len_q;
    word_d  = word_q;
    stop2_d = stop2_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d = par_en_q;
    par_d    = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (tx_en_i && !empty) begin
          pop     = 1'b1;
          state_d = S_START;
          cnt_d   = '0;
          idx_d   = '0;
          word_d  = mem_q[rptr_q];
          cpb_d   = cpb_eff;
          len_d   = len_eff;
          stop2_d = stop2_i;
`ifdef UART_TX_PARITY_EN
          par_en_d = parity_en_i;
          par_d    = (^(mem_q[rptr_q] & mask)) ^ parity_odd_i;
`endif
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_DATA: begin
        tx_d = word_q[0];
        if (bit_end) begin
          cnt_d  = '0;
          word_d = word_q >> 1;
          if (idx_q == len_q - 4'd1) begin
            idx_d   = '0;
            state_d = S_STOP;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) state_d = S_PARITY;
`endif
          end else idx_d = idx_q + 4'd1;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_d = par_q;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == {3'b000, stop2_q}) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else idx_d = idx_q + 4'd1;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx follows the current state, so the line lags the FSM by one clock
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cpb_q   <= CNT_W'(1);
      idx_q   <= '0;
      len_q   <= 4'(DATA_W);
      word_q  <= '0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cpb_q   <= cpb_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      word_q  <= word_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q <= par_en_d;
      par_q    <= par_d;
`endif
    end
  end

  assign wready_o     = !full;
  assign fifo_level_o = level_q;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != S_IDLE);
  assign tx_done_o    = done_q;

endmodule
